// File: rtl/viterbi_frame_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl
//
// Frame sequencer and checker for an encoder -> channel -> Viterbi decoder loop.
// A frame is a PRBS-7 payload of frame_len bits followed by K-1 zero tail bits
// that flush the encoder trellis. Every payload bit driven to the encoder is
// also pushed into a DEC_LAT-deep check pipeline, so it lines up with the bit
// the decoder returns DEC_LAT cycles later. Decoded bits are counted and
// compared, and the per-frame totals are reported on bit_cnt / err_cnt.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active low
//   start            in   begin a frame (only looked at in IDLE)
//   abort            in   cancel the current frame, back to IDLE, no done
//   frame_len        in   payload length in bits, captured when start is taken
//   encoder_i        out  registered data bit to the encoder
//   enable_encoder_i out  registered encoder enable
//   decoder_o        in   decoded bit from the decoder
//   busy             out  high from the accepted start until done/abort
//   done             out  one-cycle pulse when a frame has fully drained
//   bit_cnt          out  payload bits compared in the current/last frame
//   err_cnt          out  mismatches in the current/last frame (saturating)
//   state_dbg        out  current FSM state, for checkers and debug
//
// Control protocol: start is a request that is accepted on any rising edge
// where the FSM is IDLE, start=1 and abort=0; it is ignored at all other
// times. busy rises the cycle after acceptance and stays high until the cycle
// done pulses (or the cycle after abort). abort is honoured on every edge in
// every state and always wins over start.
// -----------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int         K       = 3,
    parameter int         DEC_LAT = 16,
    parameter int         LEN_W   = 16,
    parameter logic [6:0] SEED    = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    output logic             encoder_i,
    output logic             enable_encoder_i,
    input  logic             decoder_o,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_cnt,
    output logic [LEN_W-1:0] err_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_TAIL    = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // cnt_q counts the cycles still to go in the current phase after the one
    // being driven, so a phase ends when cnt_q reaches zero.
    localparam logic [LEN_W-1:0] TAIL_LAST  = LEN_W'(K - 2);
    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DEC_LAT - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic               enc_q, enc_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   err_cnt_q, err_cnt_d;
    logic [DEC_LAT-1:0] pv_q, pv_d;   // check pipeline: valid flags
    logic [DEC_LAT-1:0] pb_q, pb_d;   // check pipeline: sent bits

    // x^7+x^6+1 PRBS. lfsr_q[0] is the next bit to send; the register shifts
    // right and the new bit enters at the top.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[0] ^ s[1], s[6:1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        enc_d     = enc_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;

        // The pipeline samples what is on the encoder port this cycle; only
        // payload bits are marked valid, tail and idle bits are not checked.
        for (int i = 1; i < DEC_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pb_d[i] = pb_q[i-1];
        end
        pv_d[0] = (state_q == S_PAYLOAD);
        pb_d[0] = enc_q;

        // The pipeline output lines up with decoder_o this cycle.
        if (pv_q[DEC_LAT-1]) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if ((decoder_o != pb_q[DEC_LAT-1]) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    err_cnt_d = '0;
                    en_d      = 1'b1;
                    if (frame_len != '0) begin
                        // First payload bit goes out the very next cycle.
                        state_d = S_PAYLOAD;
                        enc_d   = SEED[0];
                        lfsr_d  = lfsr_step(SEED);
                        cnt_d   = frame_len - 1'b1;
                    end else begin
                        state_d = S_TAIL;
                        enc_d   = 1'b0;
                        lfsr_d  = SEED;
                        cnt_d   = TAIL_LAST;
                    end
                end
            end
            S_PAYLOAD: begin
                if (cnt_q != '0) begin
                    enc_d  = lfsr_q[0];
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    state_d = S_TAIL;
                    enc_d   = 1'b0;
                    cnt_d   = TAIL_LAST;
                end
            end
            S_TAIL: begin
                enc_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    en_d    = 1'b0;
                    cnt_d   = DRAIN_LAST;
                end
            end
            S_DRAIN: begin
                // DEC_LAT cycles after the last tail bit every payload bit
                // has reached the compare point, so the pipeline is empty.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                enc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort beats everything: counters keep the value they already hold
        // (the compare in this cycle is dropped), in-flight bits are voided.
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            lfsr_d    = lfsr_q;
            enc_d     = 1'b0;
            en_d      = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            bit_cnt_d = bit_cnt_q;
            err_cnt_d = err_cnt_q;
            pv_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            enc_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            pv_q      <= '0;
            pb_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            enc_q     <= enc_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            pv_q      <= pv_d;
            pb_q      <= pb_d;
        end
    end

    assign encoder_i        = enc_q;
    assign enable_encoder_i = en_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign bit_cnt          = bit_cnt_q;
    assign err_cnt          = err_cnt_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for viterbi_frame_ctrl: a loopback channel (pure DEC_LAT delay with
// selectable bit inversion) stands in for encoder + decoder.
module tb_viterbi_frame_ctrl;

    localparam int         K       = 3;
    localparam int         DEC_LAT = 16;
    localparam int         LEN_W   = 16;
    localparam logic [6:0] SEED    = 7'h7F;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             encoder_i;
    logic             enable_encoder_i;
    logic             decoder_o;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] err_cnt;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .K(K), .DEC_LAT(DEC_LAT), .LEN_W(LEN_W), .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .frame_len(frame_len),
        .encoder_i(encoder_i),
        .enable_encoder_i(enable_encoder_i),
        .decoder_o(decoder_o),
        .busy(busy),
        .done(done),
        .bit_cnt(bit_cnt),
        .err_cnt(err_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- loopback channel ----------------
    // ch_idx counts enabled cycles of the current frame, so while the payload
    // is going out it equals the payload bit index.
    logic [DEC_LAT-1:0] ch_dl = '0;
    int                 ch_idx = 0;
    int                 inv_a = -1;
    int                 inv_b = -1;
    logic               inv_all = 1'b0;
    logic               ch_flip;

    always_comb ch_flip = inv_all | (enable_encoder_i & ((ch_idx == inv_a) | (ch_idx == inv_b)));

    always @(posedge clk) begin
        ch_dl  <= {ch_dl[DEC_LAT-2:0], encoder_i ^ ch_flip};
        ch_idx <= enable_encoder_i ? ch_idx + 1 : 0;
    end

    assign decoder_o = ch_dl[DEC_LAT-1];

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference frame contents: PRBS-7 recurrence s[n+7] = s[n] ^ s[n+1]
    // (x^7+x^6+1) starting from the seed bits, then K-1 zero tail bits.
    function automatic void build_exp(input int len);
        bit s[$];
        exp_q.delete();
        for (int i = 0; i < 7; i++) s.push_back(SEED[i]);
        for (int n = 0; n < len; n++) begin
            exp_q.push_back(s[n]);
            s.push_back(s[n] ^ s[n+1]);
        end
        for (int t = 0; t < K - 1; t++) exp_q.push_back(1'b0);
    endfunction

    // ---------------- driver ----------------
    task automatic run_frame(input int len, input int fa, input int fb, input logic fall,
                             input int exp_bits, input int exp_errs,
                             input int busy_start_at, input string tag);
        int exp_done;
        int n_en;
        int seq_bad;
        int done_cyc;
        int busy_gap;
        inv_a    = fa;
        inv_b    = fb;
        inv_all  = fall;
        // Accept edge ends cycle 0; payload starts cycle 1.
        exp_done = len + (K - 1) + DEC_LAT + 1;
        build_exp(len);
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = LEN_W'(len);
        @(posedge clk); #1;
        start    = 1'b0;
        n_en     = 0;
        seq_bad  = 0;
        done_cyc = -1;
        busy_gap = 0;
        for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
            @(negedge clk);
            if (enable_encoder_i) begin
                n_en++;
                if (exp_q.size() == 0) seq_bad++;
                else if (encoder_i !== exp_q.pop_front()) seq_bad++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_gap++;
            if (busy_start_at > 0 && cyc == busy_start_at) begin
                start     = 1'b1;
                frame_len = LEN_W'(5);
            end else if (busy_start_at > 0 && cyc == busy_start_at + 1) begin
                start     = 1'b0;
                frame_len = LEN_W'(len);
            end
        end
        check({tag, ".done_cycle"}, done_cyc, exp_done);
        check({tag, ".enable_cycles"}, n_en, len + K - 1);
        check({tag, ".enc_seq_errors"}, seq_bad, 0);
        check({tag, ".busy_low_early"}, busy_gap, 0);
        @(negedge clk);
        check({tag, ".done_width"}, done, 0);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".bit_cnt"}, bit_cnt, exp_bits);
        check({tag, ".err_cnt"}, err_cnt, exp_errs);
        inv_a   = -1;
        inv_b   = -1;
        inv_all = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   len;
        int   fa;
        int   fb;
        logic fall;
        int   exp_bits;
        int   exp_errs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int fa;
        int fb;
        int ee;
        int dcount;

        vecs[0] = '{100, -1, -1, 1'b0, 100, 0};   // clean loopback
        vecs[1] = '{100,  5,  6, 1'b0, 100, 2};   // two payload bits corrupted
        vecs[2] = '{  0, -1, -1, 1'b0,   0, 0};   // tail only
        vecs[3] = '{ 10, -1, -1, 1'b0,  10, 0};   // PRBS check
        vecs[4] = '{ 10, -1, -1, 1'b0,  10, 0};   // PRBS repeats from seed
        vecs[5] = '{  1,  0, -1, 1'b0,   1, 1};   // single bit, corrupted
        vecs[6] = '{ 30, -1, -1, 1'b1,  30, 30};  // every bit corrupted
        vecs[7] = '{  8,  7,  7, 1'b0,   8, 1};   // last payload bit
        vecs[8] = '{  5,  5, -1, 1'b0,   5, 0};   // corrupt tail bit: not counted

        // reset state
        #12;
        check("reset.enable", enable_encoder_i, 0);
        check("reset.encoder", encoder_i, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.bit_cnt", bit_cnt, 0);
        check("reset.err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].len, vecs[v].fa, vecs[v].fb, vecs[v].fall,
                      vecs[v].exp_bits, vecs[v].exp_errs, 0, $sformatf("vec%0d", v));
        end

        // randomized frames against the reference model
        for (int r = 0; r < 10; r++) begin
            len = int'($urandom_range(0, 200));
            fa  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len + 2)) : -1;
            fb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len + 2)) : -1;
            ee  = ((fa >= 0 && fa < len) ? 1 : 0) + ((fb >= 0 && fb < len && fb != fa) ? 1 : 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame(len, fa, fb, 1'b0, len, ee, 0, $sformatf("rnd%0d", r));
        end

        // abort during payload cycle 20
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = LEN_W'(50);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abort.enable_before", enable_encoder_i, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.enable_after", enable_encoder_i, 0);
        check("abort.busy_after", busy, 0);
        // bits sent in cycles 1..3 were compared at the ends of cycles 17..19;
        // the compare in the abort cycle is dropped
        check("abort.bit_cnt_held", bit_cnt, 20 - DEC_LAT - 1);
        check("abort.err_cnt_held", err_cnt, 0);
        dcount = 0;
        for (int c = 0; c < DEC_LAT + 5; c++) begin
            @(negedge clk);
            if (done || busy || enable_encoder_i) dcount++;
        end
        check("abort.no_activity", dcount, 0);
        run_frame(40, -1, -1, 1'b0, 40, 0, 0, "post_abort");

        // start and abort together in IDLE: nothing starts, counters held
        @(posedge clk); #1;
        start     = 1'b1;
        abort     = 1'b1;
        frame_len = LEN_W'(12);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort.busy", busy, 0);
        check("start_abort.enable", enable_encoder_i, 0);
        check("start_abort.bit_cnt", bit_cnt, 40);

        // async reset mid-frame
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = LEN_W'(40);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid.enable", enable_encoder_i, 0);
        check("rst_mid.encoder", encoder_i, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.bit_cnt", bit_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || enable_encoder_i) dcount++;
        end
        check("rst_mid.no_done", dcount, 0);
        run_frame(10, -1, -1, 1'b0, 10, 0, 0, "post_rst");

        // maximum length, every bit inverted, start while busy ignored
        run_frame(65535, -1, -1, 1'b1, 65535, 65535, 100, "sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
